// File: rtl/segment7_pkg.sv
// -----------------------------------------------------------------------------
// segment7_pkg
//   Shared types and default constants for the segment7 display path.
//
//   polarity_t   : segment/digit drive polarity used by the segment7 decoder.
//   digit_t      : one BCD/hex digit value presented to the decoder.
//   scan_state_t : phase of the multiplexing scheduler within one digit slot.
//                  IDLE  - not scanning, all digits dark
//                  BLANK - anti-ghosting gap at the start of each slot
//                  ON    - digit lit for the brightness-scaled on-time
//                  OFF   - digit dark for the remainder of the slot
//
//   DEF_* localparams carry the default scan timing so that instantiating
//   modules and the display top agree on one set of numbers.
// -----------------------------------------------------------------------------
package segment7_pkg;

  typedef enum logic {
    ACTIVE_LOW  = 1'b0,
    ACTIVE_HIGH = 1'b1
  } polarity_t;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2,
    OFF   = 2'd3
  } scan_state_t;

  localparam int DEF_SEGMENTS     = 4;
  localparam int DEF_DWELL_CYCLES = 1000;
  localparam int DEF_BLANK_CYCLES = 16;
  localparam int DEF_BRIGHT_BITS  = 4;
  localparam int DEF_BLINK_FRAMES = 64;

  // A digit is only driven while the scheduler sits in ON.
  function automatic logic state_is_lit(input scan_state_t s);
    return (s == ON);
  endfunction

endpackage

// File: rtl/segment7_pwm_timer.sv
// -----------------------------------------------------------------------------
// segment7_pwm_timer
//   Per-slot timing engine for segment7_scan_ctrl. Owns the dwell counter,
//   the brightness-scaled on-time and the decode of slot phase boundaries.
//
//   Ports
//     clk            in  system clock
//     rst            in  asynchronous reset, active-high
//     i_active       in  slot timing is running (scanning and not IDLE);
//                        when low the dwell counter is held at 0
//     i_brightness   in  on-time level, captured on the first cycle of a slot
//     o_blank_end    out last cycle of the BLANK interval
//     o_on_end       out last cycle of the ON interval (never when on-time = 0)
//     o_slot_end     out last cycle of the slot (dwell_cnt = DWELL_CYCLES-1)
//     o_pre_slot_end out cycle before the last cycle of the slot
//     o_on_zero      out on-time of the current slot is zero clocks
// -----------------------------------------------------------------------------
module segment7_pwm_timer
  import segment7_pkg::*;
#(
  parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int BRIGHT_BITS  = DEF_BRIGHT_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_active,
  input  logic [BRIGHT_BITS-1:0] i_brightness,
  output logic                   o_blank_end,
  output logic                   o_on_end,
  output logic                   o_slot_end,
  output logic                   o_pre_slot_end,
  output logic                   o_on_zero
);

  localparam int CNT_W  = $clog2(DWELL_CYCLES);
  localparam int SPAN   = DWELL_CYCLES - BLANK_CYCLES;
  // SPAN < 2**CNT_W and (level) <= 2**BRIGHT_BITS, so the product always
  // fits in CNT_W+BRIGHT_BITS bits; one extra bit keeps the +1 safe.
  localparam int PROD_W = CNT_W + BRIGHT_BITS + 1;

  logic [CNT_W-1:0]       r_dwell_cnt;
  logic [BRIGHT_BITS-1:0] r_bright_q;
  logic [BRIGHT_BITS-1:0] w_bright;
  logic                   w_slot_first;
  logic [CNT_W:0]         w_on_cycles;
  logic [CNT_W:0]         w_on_last;

  // on_cycles = (SPAN * (level+1)) >> BRIGHT_BITS, multiplied at full width
  // so no precision is lost before the shift.
  function automatic logic [CNT_W:0] scale_on(input logic [BRIGHT_BITS-1:0] lvl);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(SPAN) * (PROD_W'(lvl) + PROD_W'(1));
    return (CNT_W+1)'(prod >> BRIGHT_BITS);
  endfunction

  // The brightness register only loads at the end of the first slot cycle.
  // On that cycle the live input is used directly so that a slot with a
  // one-clock blank still sees this slot's level at its BLANK->ON decision.
  assign w_slot_first = i_active && (r_dwell_cnt == '0);
  assign w_bright     = w_slot_first ? i_brightness : r_bright_q;
  assign w_on_cycles  = scale_on(w_bright);
  assign w_on_last    = (CNT_W+1)'(BLANK_CYCLES) + w_on_cycles - (CNT_W+1)'(1);

  // Stage p0: phase boundary decode from the current dwell count
  assign o_on_zero      = (w_on_cycles == '0);
  assign o_blank_end    = i_active && (r_dwell_cnt == CNT_W'(BLANK_CYCLES - 1));
  assign o_on_end       = i_active && !o_on_zero &&
                          ({1'b0, r_dwell_cnt} == w_on_last);
  assign o_slot_end     = i_active && (r_dwell_cnt == CNT_W'(DWELL_CYCLES - 1));
  assign o_pre_slot_end = i_active && (r_dwell_cnt == CNT_W'(DWELL_CYCLES - 2));

  // Stage p1: dwell counter and brightness capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwell_cnt <= '0;
    end else if (!i_active || o_slot_end) begin
      r_dwell_cnt <= '0;
    end else begin
      r_dwell_cnt <= r_dwell_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_slot_first) begin
      r_bright_q <= i_brightness;
    end
  end

endmodule

// File: rtl/segment7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// segment7_scan_ctrl
//   Time-multiplexing scheduler for the segment7 decoder. Each digit gets a
//   fixed dwell slot: a leading blank interval (anti-ghosting), then a
//   brightness-scaled on-time, then off-time. Generates the digit index and
//   the lit strobe consumed by segment7, plus a frame-complete pulse.
//
//   Optional feature macro: SEGMENT7_BLINK_EN
//     Adds per-digit blinking. A frame counter counts frame_done pulses and
//     toggles blink_phase every BLINK_FRAMES frames; while blink_phase is high
//     digits selected by blink_mask stay dark during ON. Slot timing is not
//     affected.
//
//   Ports
//     clk         in  system clock
//     rst         in  asynchronous reset, active-high
//     run         in  scanning enabled while high; low returns to IDLE
//     brightness  in  on-time level (0 = dimmest, all-ones = full)
//     counter     out current digit index (registered)
//     enable      out digit lit (registered)
//     frame_done  out one-cycle pulse on the last cycle of the last digit slot
//     blink_mask  in  per-digit blink select   (SEGMENT7_BLINK_EN only)
//     blink_phase out current blink half-period (SEGMENT7_BLINK_EN only)
// -----------------------------------------------------------------------------
module segment7_scan_ctrl
  import segment7_pkg::*;
#(
  parameter int SEGMENTS     = DEF_SEGMENTS,
  parameter int DWELL_CYCLES = DEF_DWELL_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int BRIGHT_BITS  = DEF_BRIGHT_BITS,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  input  logic [BRIGHT_BITS-1:0]      brightness,
  output logic [$clog2(SEGMENTS)-1:0] counter,
  output logic                        enable,
  output logic                        frame_done
`ifdef SEGMENT7_BLINK_EN
  ,
  input  logic [SEGMENTS-1:0]         blink_mask,
  output logic                        blink_phase
`endif
);

  localparam int                CW   = $clog2(SEGMENTS);
  localparam logic [CW-1:0]     LAST = CW'(SEGMENTS - 1);

  // Elaboration-time parameter checks
  if ((SEGMENTS < 2) || ((SEGMENTS & (SEGMENTS - 1)) != 0)) begin : g_bad_segments
    $fatal(1, "segment7_scan_ctrl: SEGMENTS must be a power of 2 and >= 2");
  end
  if (BLANK_CYCLES < 1) begin : g_bad_blank_min
    $fatal(1, "segment7_scan_ctrl: BLANK_CYCLES must be >= 1");
  end
  if (BLANK_CYCLES >= DWELL_CYCLES) begin : g_bad_blank_max
    $fatal(1, "segment7_scan_ctrl: BLANK_CYCLES must be < DWELL_CYCLES");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $fatal(1, "segment7_scan_ctrl: BLINK_FRAMES must be >= 1");
  end

  scan_state_t   r_state;
  scan_state_t   w_state_nxt;
  logic [CW-1:0] r_counter;
  logic [CW-1:0] w_counter_nxt;
  logic          r_enable;
  logic          w_enable_nxt;
  logic          r_frame_done;
  logic          w_frame_done_nxt;
  logic          w_active;
  logic          w_blank_end;
  logic          w_on_end;
  logic          w_slot_end;
  logic          w_pre_slot_end;
  logic          w_on_zero;

  // Slot timing only runs while scanning; dropping run clears it at once.
  assign w_active = run && (r_state != IDLE);

  segment7_pwm_timer #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES),
    .BRIGHT_BITS  (BRIGHT_BITS)
  ) u_pwm_timer (
    .clk            (clk),
    .rst            (rst),
    .i_active       (w_active),
    .i_brightness   (brightness),
    .o_blank_end    (w_blank_end),
    .o_on_end       (w_on_end),
    .o_slot_end     (w_slot_end),
    .o_pre_slot_end (w_pre_slot_end),
    .o_on_zero      (w_on_zero)
  );

`ifdef SEGMENT7_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0] r_frame_cnt;
  logic            r_blink_phase;
  logic            w_frame_wrap;
  logic            w_blink_phase_nxt;

  // frame_done is registered, so its high cycle is where a frame is counted.
  assign w_frame_wrap      = r_frame_done && (r_frame_cnt == FC_W'(BLINK_FRAMES - 1));
  assign w_blink_phase_nxt = w_frame_wrap ? ~r_blink_phase : r_blink_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_blink_phase <= w_blink_phase_nxt;
      if (!run || w_frame_wrap) begin
        r_frame_cnt <= '0;
      end else if (r_frame_done) begin
        r_frame_cnt <= r_frame_cnt + FC_W'(1);
      end
    end
  end

  assign blink_phase = r_blink_phase;
`endif

  // Stage p0: next-state, digit index and registered-output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_counter_nxt = r_counter;
    if (!run) begin
      w_state_nxt   = IDLE;
      w_counter_nxt = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt   = BLANK;
          w_counter_nxt = '0;
        end
        BLANK: begin
          // A zero on-time goes straight to OFF so ON is never zero length.
          if (w_blank_end) begin
            w_state_nxt = w_on_zero ? OFF : ON;
          end
        end
        ON: begin
          // Full brightness ends ON on the slot's last cycle: OFF is skipped.
          if (w_slot_end) begin
            w_state_nxt = BLANK;
          end else if (w_on_end) begin
            w_state_nxt = OFF;
          end
        end
        OFF: begin
          if (w_slot_end) begin
            w_state_nxt = BLANK;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
      // Power-of-2 digit count makes the natural wrap SEGMENTS-1 -> 0.
      if (w_slot_end) begin
        w_counter_nxt = r_counter + CW'(1);
      end
    end
  end

  always_comb begin
    w_enable_nxt = state_is_lit(w_state_nxt);
`ifdef SEGMENT7_BLINK_EN
    if (w_blink_phase_nxt && blink_mask[w_counter_nxt]) begin
      w_enable_nxt = 1'b0;
    end
`endif
  end

  // Registered so that frame_done is high on the last cycle of the last
  // digit, i.e. the cycle whose edge moves counter from SEGMENTS-1 to 0.
  assign w_frame_done_nxt = w_pre_slot_end && (r_counter == LAST);

  // Stage p1: state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_counter    <= '0;
      r_enable     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_counter    <= w_counter_nxt;
      r_enable     <= w_enable_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign counter    = r_counter;
  assign enable     = r_enable;
  assign frame_done = r_frame_done;

endmodule

// File: doc/segment7_scan_ctrl.md
Name: segment7_scan_ctrl

Overview:
Time-multiplexing scheduler for the segment7 display decoder. It generates the digit-select `counter` and the `enable` strobe that segment7 consumes.
- Each digit gets a fixed dwell slot. The slot opens with an anti-ghosting blank interval, then a brightness-scaled on-time, then off-time.
- Sits between the clock domain and segment7 in the alarm-clock display path.

Parameters:
- SEGMENTS, 4: number of digits; must be a power of 2 and ≥ 2.
- DWELL_CYCLES, 1000: clocks per digit slot, including blank time.
- BLANK_CYCLES, 16: leading blank clocks per slot; must be ≥ 1 and < DWELL_CYCLES.
- BRIGHT_BITS, 4: width of the brightness input.
- BLINK_FRAMES, 64: full scan frames per blink half-period; used only with SEGMENT7_BLINK_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- run  in  1  scanning enabled while high.
- brightness  in  BRIGHT_BITS  on-time level; 0 = dimmest, all-ones = full.
- counter  out  $clog2(SEGMENTS)  current digit index; drives segment7 counter.
- enable  out  1  digit lit; drives segment7 enable.
- frame_done  out  1  one-cycle pulse at the end of the last digit's slot.
- blink_mask  in  SEGMENTS  per-digit blink select (SEGMENT7_BLINK_EN only).
- blink_phase  out  1  current blink half-period (SEGMENT7_BLINK_EN only).

Behaviour:
- One clock domain: clk. rst is asynchronous, active-high. All outputs are registered.
- Reset values: state=IDLE, counter=0, enable=0, frame_done=0, dwell_cnt=0, blink_phase=0, frame count=0.
- States (scan_state_t): IDLE, BLANK, ON, OFF. enable=1 only in ON.
- Slot timing:
  - dwell_cnt counts 0..DWELL_CYCLES-1 within a slot.
  - BLANK: dwell_cnt 0..BLANK_CYCLES-1.
  - ON: the next on_cycles clocks.
  - OFF: the remainder of the slot.
- on_cycles = ((DWELL_CYCLES-BLANK_CYCLES)*(brightness_q+1)) >> BRIGHT_BITS.
  - Compute at full width, with no truncation before the shift.
  - If on_cycles = 0, skip ON entirely; ON → OFF is never entered with zero length.
  - If on_cycles equals the full post-blank span, OFF is skipped.
- brightness_q is sampled on the first cycle of each slot. A brightness change mid-slot takes effect from the next slot.
- Slot end: on the cycle with dwell_cnt = DWELL_CYCLES-1:
  - next cycle: dwell_cnt=0, state=BLANK;
  - counter increments, wrapping SEGMENTS-1 → 0.
- frame_done is high for exactly the one cycle in which counter changes from SEGMENTS-1 to 0.
- IDLE with run=1: next cycle is BLANK, counter=0, dwell_cnt=0.
- run=0 in any state: next cycle is IDLE, enable=0, counter=0, dwell_cnt=0, frame_done=0.
  - No partial frame_done is produced.
  - The blink frame count is cleared.
- BLANK_CYCLES ≥ 1 guarantees enable drops for at least one cycle on every digit change.
- Reset mid-slot: all state returns to the reset values above immediately, because rst is asynchronous.
- Parameter violations (SEGMENTS not a power of 2, BLANK_CYCLES = 0, BLANK_CYCLES ≥ DWELL_CYCLES) raise $fatal at elaboration.

Optional Feature:
- Macro: SEGMENT7_BLINK_EN.
- When defined:
  - Adds blink_mask and blink_phase.
  - A frame counter counts frame_done pulses. blink_phase toggles after every BLINK_FRAMES frames, and the counter then restarts.
  - While blink_phase=1 and blink_mask[counter]=1, enable is forced 0 during ON. State timing is unchanged.
  - blink_mask is sampled live.
- When undefined:
  - Ports, frame counter and BLINK_FRAMES logic are absent.
  - enable follows state only.

Decomposition:
- segment7_pkg gains:
  - scan_state_t enum: IDLE, BLANK, ON, OFF.
  - Default-timing localparams.
- Existing polarity_t and digit_t are untouched.
- Sub-module segment7_pwm_timer is natural. It owns dwell_cnt, the on_cycles computation and the phase decode, and returns the slot_end, blank_end and on_end strobes to the FSM.

Test Plan:
All directed tests use SEGMENTS=4, DWELL_CYCLES=20, BLANK_CYCLES=4, BRIGHT_BITS=2.
1. Reset, run=1, brightness=3:
   - counter cycles 0,1,2,3,0.
   - enable is low 4 clocks, then high 16 clocks, per slot.
   - frame_done pulses once every 80 clocks, aligned with counter 3 → 0.
2. brightness=0 → per slot: 4 blank, 4 on, 12 off. brightness=1 → 8 on, 8 off.
   - Changing brightness 1 → 2 mid-slot leaves the current slot at 8 on; the next slot has 12 on.
3. Drop run in the ON state of digit 2:
   - next cycle enable=0, counter=0, no frame_done.
   - Re-assert run: BLANK restarts at digit 0.
4. Assert rst asynchronously mid-ON:
   - enable=0, counter=0 without waiting for a clock edge.
   - After release, scanning resumes from IDLE.
5. Check that enable is never high on two adjacent cycles with different counter values, across 1000 random brightness changes.
6. (SEGMENT7_BLINK_EN, BLINK_FRAMES=2, blink_mask=4'b0010):
   - blink_phase toggles every 160 clocks.
   - While blink_phase=1, digit 1 never lights and digits 0, 2 and 3 light normally.
